// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 write-side scheduler.
// Used by the scheduler top and its address generator.
package ddr3_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_XFER
  } state_t;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int DATA_W = 256;

endpackage

// File: rtl/ddr3_addr_gen.sv
// Circular DDR3 address generator for one region of BL8 words.
// Emits a one-cycle wrap pulse on return to the base address.
module ddr3_addr_gen #(
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int REGION_WORDS = 65536,
  parameter int ADDR_INC = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam int IDX_W = $clog2(REGION_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REGION_WORDS - 1);

  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wrap_q;
  logic              last;

  assign last = (idx_q == IDX_LAST);
  assign addr = addr_q;
  assign wrap = wrap_q;

  // Word index and address advance together; last word returns to base.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q  <= '0;
      addr_q <= BASE_ADDR;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clr) begin
        idx_q  <= '0;
        addr_q <= BASE_ADDR;
      end else if (step) begin
        if (last) begin
          idx_q  <= '0;
          addr_q <= BASE_ADDR;
          wrap_q <= 1'b1;
        end else begin
          idx_q  <= idx_q + IDX_W'(1);
          addr_q <= addr_q + ADDR_W'(ADDR_INC);
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_wr_sched.sv
// Drains the acquisition FIFO into DDR3, one BL8 write per word.
// Command and data channels handshake independently per word.
module ddr3_wr_sched
  import ddr3_sched_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int REGION_WORDS = 65536,
  parameter int ADDR_INC = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              clr,
  input  logic              init_calib_complete,
  input  logic              fifo_rdy,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              busy,
  output logic [31:0]       wr_count,
  output logic              wrap
);

  state_t state_q;
  state_t state_d;

  logic        cmd_acc_q;
  logic        dat_acc_q;
  logic [31:0] wr_count_q;

  logic cmd_hit;
  logic dat_hit;
  logic done;
  logic clr_hit;

  ddr3_addr_gen #(
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (BASE_ADDR),
    .REGION_WORDS (REGION_WORDS),
    .ADDR_INC     (ADDR_INC)
  ) u_addr (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr_hit),
    .step (done),
    .addr (app_addr),
    .wrap (wrap)
  );

  assign app_cmd      = APP_CMD_WR;
  assign app_wdf_data = fifo_dout;
  assign app_wdf_end  = app_wdf_wren;
  assign fifo_rd_en   = done;
  assign busy         = (state_q == ST_XFER);
  assign wr_count     = wr_count_q;

  // Next state and channel strobes; a word pops only once both sides took it.
  always_comb begin
    state_d      = state_q;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    cmd_hit      = 1'b0;
    dat_hit      = 1'b0;
    done         = 1'b0;
    clr_hit      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (init_calib_complete && fifo_rdy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr) clr_hit = 1'b1;
        else if (enable && !fifo_empty) state_d = ST_XFER;
      end
      ST_XFER: begin
        app_en       = !fifo_empty && !cmd_acc_q;
        app_wdf_wren = !fifo_empty && !dat_acc_q;
        cmd_hit      = app_en && app_rdy;
        dat_hit      = app_wdf_wren && app_wdf_rdy;
        done = (cmd_acc_q || cmd_hit) && (dat_acc_q || dat_hit);
        if (done) begin
          if (!enable) state_d = ST_IDLE;
        end else if (fifo_empty && !cmd_acc_q && !dat_acc_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Per-channel accept flags held until the word completes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cmd_acc_q <= 1'b0;
      dat_acc_q <= 1'b0;
    end else if (done) begin
      cmd_acc_q <= 1'b0;
      dat_acc_q <= 1'b0;
    end else begin
      cmd_acc_q <= cmd_acc_q || cmd_hit;
      dat_acc_q <= dat_acc_q || dat_hit;
    end
  end

  // Committed word counter, free-running modulo 2^32.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        wr_count_q <= '0;
    else if (clr_hit) wr_count_q <= '0;
    else if (done)    wr_count_q <= wr_count_q + 32'd1;
  end

endmodule

// File: tb/tb_ddr3_wr_sched.sv
// Bench for ddr3_wr_sched: FWFT FIFO model plus write scoreboard.
// Scenario tasks run in sequence from one initial block.
module tb_ddr3_wr_sched;
  import ddr3_sched_pkg::*;

  localparam int AW  = 28;
  localparam int RW  = 16;
  localparam int INC = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic          clr;
  logic          calib;
  logic          fifo_rdy;
  logic          fifo_empty;
  logic [255:0]  fifo_dout;
  logic          fifo_rd_en;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [255:0]  app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          busy;
  logic [31:0]   wr_count;
  logic          wrap;

  int vec  = 0;
  int errs = 0;

  logic [255:0] fq[$];
  logic [255:0] sb[$];
  logic [255:0] mon_w;
  int exp_idx  = 0;
  bit wrap_exp = 1'b0;
  int wrap_n   = 0;
  bit mon_on   = 1'b0;

  always #5 clk = ~clk;

  ddr3_wr_sched #(
    .ADDR_W       (AW),
    .BASE_ADDR    ('0),
    .REGION_WORDS (RW),
    .ADDR_INC     (INC)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .enable              (enable),
    .clr                 (clr),
    .init_calib_complete (calib),
    .fifo_rdy            (fifo_rdy),
    .fifo_empty          (fifo_empty),
    .fifo_dout           (fifo_dout),
    .fifo_rd_en          (fifo_rd_en),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .busy                (busy),
    .wr_count            (wr_count),
    .wrap                (wrap)
  );

  task automatic fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push_word(input logic [255:0] w);
    fq.push_back(w);
    sb.push_back(w);
    fifo_refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // FWFT FIFO model: pop on the edge that sees rd_en.
  always @(posedge clk) begin
    if (nrst === 1'b1 && fifo_rd_en === 1'b1 && fq.size() > 0)
      void'(fq.pop_front());
    #1 fifo_refresh();
  end

  // Scoreboard monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_on && nrst === 1'b1) begin
      vec++;
      if (wrap !== wrap_exp) begin
        errs++;
        $display("FAIL wrap: got %b want %b t=%0t", wrap, wrap_exp, $time);
      end
      if (wrap === 1'b1) wrap_n++;
      wrap_exp = 1'b0;
      if (app_wdf_wren || app_wdf_end) begin
        vec++;
        if (app_wdf_end !== app_wdf_wren) begin
          errs++;
          $display("FAIL wdf_end: got %b want %b", app_wdf_end, app_wdf_wren);
        end
      end
      if (app_en) begin
        vec++;
        if (app_cmd !== APP_CMD_WR) begin
          errs++;
          $display("FAIL app_cmd: got %0d want 0", app_cmd);
        end
      end
      if (fifo_rd_en === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL pop: got rd_en with no word outstanding t=%0t", $time);
        end else begin
          mon_w = sb.pop_front();
          if (app_wdf_data !== mon_w) begin
            errs++;
            $display("FAIL wdf_data: got %h want %h", app_wdf_data, mon_w);
          end
          vec++;
          if (app_addr !== AW'(exp_idx * INC)) begin
            errs++;
            $display("FAIL app_addr: got %0d want %0d", app_addr, exp_idx * INC);
          end
          if (exp_idx == RW - 1) begin
            exp_idx  = 0;
            wrap_exp = 1'b1;
          end else begin
            exp_idx++;
          end
        end
      end
    end
  end

  task automatic chk_count(input string tag, input logic [31:0] want);
    vec++;
    if (wr_count !== want) begin
      errs++;
      $display("FAIL %s: wr_count got %0d want %0d", tag, wr_count, want);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((fq.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (n >= 500) begin
      errs++;
      $display("FAIL %s: drain timeout got %0d words left want 0", tag, fq.size());
    end
    tick(1);
  endtask

  task automatic do_clr();
    enable = 1'b0;
    tick(3);
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_idle: busy got %b want 0", busy);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_idx = 0;
    chk_count("clr_count", 32'd0);
    vec++;
    if (app_addr !== '0) begin
      errs++;
      $display("FAIL clr_addr: got %0d want 0", app_addr);
    end
  endtask

  task automatic test_reset();
    #1;
    vec++;
    if ({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, wrap, busy} !== 6'b0) begin
      errs++;
      $display("FAIL reset_strobes: got %b want 000000",
               {app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, wrap, busy});
    end
    chk_count("reset_count", 32'd0);
    vec++;
    if (app_addr !== '0) begin
      errs++;
      $display("FAIL reset_addr: got %0d want 0", app_addr);
    end
    #19 nrst = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_startup();
    int early;
    bit got;
    early = 0;
    got   = 1'b0;
    #80;
    fifo_rdy    = 1'b1;
    enable      = 1'b1;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    #50 push_word(256'h5a5a_0001);
    while ($time < 300) begin
      @(negedge clk);
      if (app_en || busy) early++;
    end
    calib = 1'b1;
    vec++;
    if (early != 0) begin
      errs++;
      $display("FAIL startup_gate: got %0d active cycles want 0", early);
    end
    for (int i = 0; i < 2 && !got; i++) begin
      @(negedge clk);
      if (app_en) got = 1'b1;
    end
    vec++;
    if (!got) begin
      errs++;
      $display("FAIL startup_first_en: got none within 2 cycles want app_en");
    end
    vec++;
    if (app_addr !== '0) begin
      errs++;
      $display("FAIL startup_addr: got %0d want 0", app_addr);
    end
    wait_drain("startup");
    chk_count("startup_count", 32'd1);
  endtask

  task automatic test_streaming();
    int n;
    int first;
    int last;
    int w0;
    n = 0;
    first = -1;
    last = -1;
    do_clr();
    w0 = wrap_n;
    for (int i = 1; i <= 16; i++) push_word(256'(i));
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    vec++;
    if (n != 16) begin
      errs++;
      $display("FAIL stream_pops: got %0d want 16", n);
    end
    vec++;
    if (last - first != 15) begin
      errs++;
      $display("FAIL stream_span: got %0d want 15", last - first);
    end
    wait_drain("stream");
    chk_count("stream_count", 32'd16);
    vec++;
    if (wrap_n - w0 != 1) begin
      errs++;
      $display("FAIL stream_wrap: got %0d pulses want 1", wrap_n - w0);
    end
  endtask

  task automatic test_split();
    int en_n;
    int wr_n;
    int rd_n;
    bit seen;
    en_n = 0;
    wr_n = 0;
    rd_n = 0;
    seen = 1'b0;
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b1;
    push_word({8{32'hc0de_0000}});
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (app_en) seen = 1'b1;
    end
    vec++;
    if (!seen) begin
      errs++;
      $display("FAIL split_start: got no app_en want app_en");
    end
    en_n = int'(app_en);
    wr_n = int'(app_wdf_wren);
    rd_n = int'(fifo_rd_en);
    repeat (4) begin
      @(negedge clk);
      en_n += int'(app_en);
      wr_n += int'(app_wdf_wren);
      rd_n += int'(fifo_rd_en);
    end
    vec++;
    if (rd_n != 0) begin
      errs++;
      $display("FAIL split_early_pop: got %0d want 0", rd_n);
    end
    @(posedge clk);
    #1 app_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      en_n += int'(app_en);
      wr_n += int'(app_wdf_wren);
      rd_n += int'(fifo_rd_en);
    end
    vec++;
    if (en_n != 6) begin
      errs++;
      $display("FAIL split_app_en: got %0d cycles want 6", en_n);
    end
    vec++;
    if (wr_n != 1) begin
      errs++;
      $display("FAIL split_wren: got %0d cycles want 1", wr_n);
    end
    vec++;
    if (rd_n != 1) begin
      errs++;
      $display("FAIL split_pop: got %0d want 1", rd_n);
    end
    tick(1);
    chk_count("split_count", 32'd17);
  endtask

  task automatic test_wrap();
    int n;
    int w0;
    n = 0;
    do_clr();
    w0 = wrap_n;
    for (int i = 0; i < 20; i++) push_word({$urandom, $urandom, 192'(i)});
    enable = 1'b1;
    while ((fq.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      app_rdy     = 1'($urandom_range(0, 1));
      app_wdf_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    wait_drain("wrap");
    chk_count("wrap_count", 32'd20);
    vec++;
    if (wrap_n - w0 != 1) begin
      errs++;
      $display("FAIL wrap_pulses: got %0d want 1", wrap_n - w0);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int c;
    int act;
    n = 0;
    c = 0;
    act = 0;
    do_clr();
    for (int i = 0; i < 6; i++) push_word(256'(32'hd000 + i));
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    enable      = 1'b1;
    while (n < 2 && c < 20) begin
      @(negedge clk);
      if (fifo_rd_en) n++;
      c++;
    end
    @(posedge clk);
    #1 app_rdy = 1'b0;
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    vec++;
    if ({app_en, app_wdf_wren} !== 2'b10) begin
      errs++;
      $display("FAIL drop_pending: got en/wren %b want 10", {app_en, app_wdf_wren});
    end
    tick(2);
    app_rdy = 1'b1;
    @(negedge clk);
    vec++;
    if (fifo_rd_en !== 1'b1) begin
      errs++;
      $display("FAIL drop_complete: rd_en got %b want 1", fifo_rd_en);
    end
    tick(1);
    chk_count("drop_count", 32'd3);
    repeat (10) begin
      @(negedge clk);
      if (app_en || busy) act++;
    end
    vec++;
    if (act != 0 || fq.size() != 3) begin
      errs++;
      $display("FAIL drop_idle: got %0d active, %0d left want 0, 3", act, fq.size());
    end
  endtask

  task automatic test_clr_reset();
    bit seen;
    seen = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) push_word(256'(32'he000 + i));
    enable = 1'b1;
    wait_drain("clr_fill");
    chk_count("clr_before", 32'd10);
    do_clr();
    push_word(256'h0bad_cafe);
    enable = 1'b1;
    wait_drain("clr_after");
    chk_count("clr_next", 32'd1);
    app_rdy = 1'b0;
    push_word(256'h0dead);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (app_en) seen = 1'b1;
    end
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    nrst = 1'b0;
    #1;
    vec++;
    if ({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, wrap, busy} !== 6'b0) begin
      errs++;
      $display("FAIL async_reset: got %b want 000000",
               {app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, wrap, busy});
    end
    chk_count("async_count", 32'd0);
    fq.delete();
    sb.delete();
    exp_idx  = 0;
    wrap_exp = 1'b0;
    fifo_refresh();
    calib   = 1'b0;
    app_rdy = 1'b1;
    push_word(256'h1111);
    tick(2);
    nrst   = 1'b1;
    mon_on = 1'b1;
    seen   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (app_en || busy) seen = 1'b1;
    end
    vec++;
    if (seen) begin
      errs++;
      $display("FAIL init_hold: got activity before calib want none");
    end
    calib = 1'b1;
    wait_drain("restart");
    chk_count("restart_count", 32'd1);
    calib    = 1'b0;
    fifo_rdy = 1'b0;
    push_word(256'h2222);
    wait_drain("calib_drop");
    chk_count("calib_drop_count", 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst        = 1'b0;
    enable      = 1'b0;
    clr         = 1'b0;
    calib       = 1'b0;
    fifo_rdy    = 1'b0;
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    fifo_refresh();
    test_reset();
    test_startup();
    test_streaming();
    test_split();
    test_wrap();
    test_enable_drop();
    test_clr_reset();
    vec++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL leftover: got %0d unpopped words want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ddr3_wr_sched.md
Name: ddr3_wr_sched

Overview:
- Write-side scheduler between the 256-bit acquisition FIFO (fifo_256x16) and the DDR3 controller user interface.
- Drains one FIFO word per DDR3 write (one 256-bit beat = one BL8 burst) and issues the matching write command.
- Advances the DDR3 address through a circular frame region and reports progress to the PCIe register block.
- Honours FIFO readiness, DDR3 calibration and an enable from the host.

Parameters:
- ADDR_W, 28, DDR3 app address width.
- BASE_ADDR, 28'h0000000, first address of the circular region.
- REGION_WORDS, 65536, number of 256-bit words in the region; must be a power of two, at least 2.
- ADDR_INC, 8, address step per word in column units for BL8.

Ports:
- clk in 1: system clock, same domain as the FIFO read side and the DDR3 UI.
- nrst in 1: asynchronous active-low reset.
- enable in 1: host run enable, level sensitive.
- clr in 1: synchronous clear of address and counter; honoured only in IDLE.
- init_calib_complete in 1: DDR3 calibration done.
- fifo_rdy in 1: FIFO initialisation complete.
- fifo_empty in 1: FIFO empty flag. The FIFO is first-word-fall-through: fifo_dout is valid whenever fifo_empty=0.
- fifo_dout in 256: FIFO head word.
- fifo_rd_en out 1: pop strobe, one cycle per consumed word.
- app_rdy in 1: DDR3 command accept.
- app_wdf_rdy in 1: DDR3 write-data accept.
- app_en out 1: command valid.
- app_cmd out 3: command code; always 3'b000 (write).
- app_addr out ADDR_W: command address.
- app_wdf_data out 256: write data, equal to fifo_dout.
- app_wdf_wren out 1: write-data valid.
- app_wdf_end out 1: equal to app_wdf_wren (single-beat bursts).
- busy out 1: high in XFER.
- wr_count out 32: words committed since reset or clr.
- wrap out 1: one-cycle pulse when the address wraps to BASE_ADDR.

Behaviour:
- Reset values:
  - state=INIT, addr=BASE_ADDR, wr_count=0, cmd_acc=0, dat_acc=0.
  - All strobes 0: app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, wrap, busy.
- States:
  - INIT: waits for init_calib_complete=1 and fifo_rdy=1 in the same cycle, then goes to IDLE. This transition happens once per reset; later deassertion of either input is ignored.
  - IDLE: if clr=1, addr becomes BASE_ADDR and wr_count becomes 0; clr has priority over leaving IDLE that cycle. Otherwise, if enable=1 and fifo_empty=0, go to XFER.
  - XFER:
    - app_en = ~fifo_empty & ~cmd_acc.
    - app_wdf_wren = app_wdf_end = ~fifo_empty & ~dat_acc.
    - app_addr = addr; app_wdf_data = fifo_dout.
    - Outputs are combinational from registered state and flags plus fifo_empty.
- Handshakes:
  - The command and data channels are independent.
  - cmd_acc sets on app_en & app_rdy; dat_acc sets on app_wdf_wren & app_wdf_rdy.
  - Both may complete in the same cycle, and in either order.
  - Data may be accepted before the command; this is legal.
- Completion: the cycle where (cmd_acc | (app_en & app_rdy)) & (dat_acc | (app_wdf_wren & app_wdf_rdy)). In that cycle:
  - fifo_rd_en=1.
  - Flags clear next cycle; wr_count increments.
  - addr += ADDR_INC. If the new offset equals REGION_WORDS*ADDR_INC, addr becomes BASE_ADDR and wrap pulses for one cycle, aligned with the registered addr update.
  - If enable=0, go to IDLE; otherwise stay in XFER.
- Throughput: one word per cycle when app_rdy, app_wdf_rdy and FIFO data are all continuously present.
- In XFER with fifo_empty=1 and both flags clear, go to IDLE; nothing is driven that cycle.
- enable deassert mid-word: the current word completes both handshakes before returning to IDLE. A word is never split and never dropped.
- A word is never popped before both channels have accepted it. fifo_dout must stay stable while held, which the FIFO guarantees without rd_en.
- wr_count wraps modulo 2^32 with no saturation.
- Reset asserted mid-transfer: immediate return to reset values. A partially accepted word is not popped; software restarts the region.

Decomposition:
- Package ddr3_sched_pkg:
  - state enum (INIT, IDLE, XFER).
  - APP_CMD_WR=3'b000, APP_CMD_RD=3'b001.
  - DATA_W=256.
- Single module; no sub-module is needed. An optional address/wrap generator, ddr3_addr_gen, may be split out if a read-side scheduler later reuses it.

Test Plan:
- Startup gating: fifo_rdy=1 at 100ns and init_calib_complete=1 at 300ns, FIFO non-empty from 150ns -> no app_en before 300ns; first app_en within 2 cycles of calibration, app_addr=0.
- Streaming: 16 words 1..16, app_rdy=app_wdf_rdy=1 -> 16 consecutive cycles of app_en, app_wdf_data=1..16, addresses 0,8,...,120, wr_count=16, fifo_rd_en high 16 cycles.
- Split handshake: app_wdf_rdy=1 while app_rdy=0 for 5 cycles -> app_wdf_wren for 1 cycle only, app_en held 6 cycles, single fifo_rd_en after app_rdy rises, wr_count=1.
- Wrap: REGION_WORDS=4, write 6 words -> addresses 0,8,16,24,0,8; wrap pulses once after the 4th word.
- Enable drop: enable=0 while word 3 has data accepted and command pending -> word 3 completes, wr_count=3, IDLE, no further app_en while words remain in the FIFO.
- clr and reset: clr in IDLE after 10 words -> wr_count=0, app_addr=0 on the next write; nrst asserted mid-XFER -> all strobes 0 asynchronously, state INIT.
